// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the 128x32
// data memory. Port 0 is the load/store unit, port 1 the loader/debug port.
// Each transaction takes three cycles: accept, memory strobe, response.
// Build option: define DMEM_ARB_STATS_EN to add the CNT_W parameter and the
// saturating per-port accept counters stat_cnt0/stat_cnt1.
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_cnt0,
    output logic [CNT_W-1:0]  stat_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    logic   owner;
    logic   is_write;
    logic   last_grant;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   winner;

    // Round-robin choice: a lone requester always wins; on a tie the port
    // that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign winner     = req1_ready;

    // Sequencer: latch the winning command, strobe the memory for one cycle,
    // then spend one cycle presenting the response before going idle again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            is_write    <= 1'b0;
            last_grant  <= 1'b1;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner       <= winner;
                        last_grant  <= winner;
                        mem_addr    <= winner ? req1_addr  : req0_addr;
                        mem_wr_data <= winner ? req1_wdata : req0_wdata;
                        is_write    <= winner ? req1_we    : req0_we;
                        mem_wr      <= winner ? req1_we    : req0_we;
                        mem_rd      <= winner ? ~req1_we   : ~req0_we;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Responses come purely from registered state, so nothing on the request
    // side can reach them combinationally; writes answer with zero data.
    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp0_rdata = (rsp0_valid & ~is_write) ? mem_read_data : '0;
    assign rsp1_rdata = (rsp1_valid & ~is_write) ? mem_read_data : '0;

`ifdef DMEM_ARB_STATS_EN
    // Per-port accept counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (req0_ready && req0_valid && (stat_cnt0 != '1)) begin
                stat_cnt0 <= stat_cnt0 + 1'b1;
            end
            if (req1_ready && req1_valid && (stat_cnt1 != '1)) begin
                stat_cnt1 <= stat_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// 128x32 memory (registered read port) attached. A per-cycle vector table
// covers single reads/writes and a tie; hand-written sequences cover the
// round-robin stream and resets landing in ISSUE and RESP. With
// DMEM_ARB_STATS_EN defined the counters are exercised with CNT_W=2.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [6:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [6:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic [6:0]  mem_addr;
    logic        mem_wr, mem_rd;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_read_data;
`ifdef DMEM_ARB_STATS_EN
    logic [1:0]  stat_cnt0, stat_cnt1;
`endif

    int tests  = 0;
    int failed = 0;
    bit prev_wr = 1'b0;
    bit prev_rd = 1'b0;

    dmem_arbiter #(
        .ADDR_W(7),
        .DATA_W(32)
`ifdef DMEM_ARB_STATS_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_we(req0_we),
        .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_we(req1_we),
        .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr),
        .mem_wr(mem_wr),
        .mem_rd(mem_rd),
        .mem_wr_data(mem_wr_data),
        .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cnt0(stat_cnt0),
        .stat_cnt1(stat_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural data memory: write on mem_wr, read data registered every
    // edge from mem_addr; a few words are preloaded on the first edge.
    logic [31:0] mem [128];
    bit          preload_done;
    always @(posedge clk) begin
        if (!preload_done) begin
            mem[1]       <= 32'h1111_1111;
            mem[2]       <= 32'h2222_2222;
            mem[13]      <= 32'h0000_0003;
            preload_done <= 1'b1;
        end
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
        mem_read_data <= mem[mem_addr];
    end

    typedef struct {
        bit          rst_n;
        bit          v0;
        bit          we0;
        logic [6:0]  a0;
        logic [31:0] d0;
        bit          v1;
        bit          we1;
        logic [6:0]  a1;
        logic [31:0] d1;
        bit          e_rdy0;
        bit          e_rdy1;
        bit          e_rv0;
        logic [31:0] e_rd0;
        bit          e_rv1;
        logic [31:0] e_rd1;
        bit          e_wr;
        bit          e_rd;
        logic [6:0]  e_addr;
        logic [31:0] e_wdat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample at the falling edge; strobe sanity is checked every cycle.
    task automatic atNegedge();
        @(negedge clk);
        check1("strobes exclusive", {31'b0, mem_wr & mem_rd}, 32'h0);
        check1("mem_wr single cycle", {31'b0, mem_wr & prev_wr}, 32'h0);
        check1("mem_rd single cycle", {31'b0, mem_rd & prev_rd}, 32'h0);
        prev_wr = mem_wr;
        prev_rd = mem_rd;
    endtask

    task automatic toNext();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input bit r, input bit v0, input bit we0, input logic [6:0] a0,
                         input logic [31:0] d0, input bit v1, input bit we1,
                         input logic [6:0] a1, input logic [31:0] d1);
        rst_n      = r;
        req0_valid = v0;
        req0_we    = we0;
        req0_addr  = a0;
        req0_wdata = d0;
        req1_valid = v1;
        req1_we    = we1;
        req1_addr  = a1;
        req1_wdata = d1;
    endtask

    task automatic applyStimulus(input vec_t v);
        setIn(v.rst_n, v.v0, v.we0, v.a0, v.d0, v.v1, v.we1, v.a1, v.d1);
    endtask

    task automatic checkOutput(input vec_t v, input int i);
        atNegedge();
        check1($sformatf("row%0d req0_ready", i), {31'b0, req0_ready}, {31'b0, v.e_rdy0});
        check1($sformatf("row%0d req1_ready", i), {31'b0, req1_ready}, {31'b0, v.e_rdy1});
        check1($sformatf("row%0d rsp0_valid", i), {31'b0, rsp0_valid}, {31'b0, v.e_rv0});
        check1($sformatf("row%0d rsp0_rdata", i), rsp0_rdata, v.e_rd0);
        check1($sformatf("row%0d rsp1_valid", i), {31'b0, rsp1_valid}, {31'b0, v.e_rv1});
        check1($sformatf("row%0d rsp1_rdata", i), rsp1_rdata, v.e_rd1);
        check1($sformatf("row%0d mem_wr", i), {31'b0, mem_wr}, {31'b0, v.e_wr});
        check1($sformatf("row%0d mem_rd", i), {31'b0, mem_rd}, {31'b0, v.e_rd});
        check1($sformatf("row%0d mem_addr", i), {25'b0, mem_addr}, {25'b0, v.e_addr});
        check1($sformatf("row%0d mem_wr_data", i), mem_wr_data, v.e_wdat);
        toNext();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic doTxn(input bit port, input bit we, input logic [6:0] a, input logic [31:0] d);
        if (port) setIn(1, 0, 0, 0, 0, 1, we, a, d);
        else      setIn(1, 1, we, a, d, 0, 0, 0, 0);
        atNegedge();
        check1("stats txn accepted", {31'b0, port ? req1_ready : req0_ready}, 32'h1);
        toNext();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge(); toNext();
        atNegedge(); toNext();
    endtask
`endif

    int grants [$];
    int rsp0_cycles [$];
    int n_rsp1;

    initial begin
        // rst, v0,we0,a0,d0, v1,we1,a1,d1, rdy0,rdy1, rv0,rd0, rv1,rd1, wr,rd, addr,wdat
        vecs[0]  = '{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0};
        vecs[1]  = '{1, 1,0,13,0, 0,0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0};
        vecs[2]  = '{1, 1,0,13,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,1, 13,0};
        vecs[3]  = '{1, 1,0,13,0, 0,0,0,0, 0,0, 1,3, 0,0, 0,0, 13,0};
        vecs[4]  = '{1, 1,0,13,0, 0,0,0,0, 1,0, 0,0, 0,0, 0,0, 13,0};
        vecs[5]  = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,1, 13,0};
        vecs[6]  = '{1, 0,0,0,0, 0,0,0,0, 0,0, 1,3, 0,0, 0,0, 13,0};
        vecs[7]  = '{1, 0,0,0,0, 1,1,5,32'hDEADBEEF, 0,1, 0,0, 0,0, 0,0, 13,0};
        vecs[8]  = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 5,32'hDEADBEEF};
        vecs[9]  = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 5,32'hDEADBEEF};
        vecs[10] = '{1, 1,0,5,0, 0,0,0,0, 1,0, 0,0, 0,0, 0,0, 5,32'hDEADBEEF};
        vecs[11] = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,1, 5,0};
        vecs[12] = '{1, 0,0,0,0, 0,0,0,0, 0,0, 1,32'hDEADBEEF, 0,0, 0,0, 5,0};
        vecs[13] = '{1, 1,0,1,0, 1,0,2,0, 0,1, 0,0, 0,0, 0,0, 5,0};
        vecs[14] = '{1, 1,0,1,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,1, 2,0};
        vecs[15] = '{1, 1,0,1,0, 0,0,0,0, 0,0, 0,0, 1,32'h22222222, 0,0, 2,0};
        vecs[16] = '{1, 1,0,1,0, 0,0,0,0, 1,0, 0,0, 0,0, 0,0, 2,0};
        vecs[17] = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,1, 1,0};
        vecs[18] = '{1, 0,0,0,0, 0,0,0,0, 0,0, 1,32'h11111111, 0,0, 0,0, 1,0};
        vecs[19] = '{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 1,0};

        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNext();
        toNext();

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Round-robin stream: both ports hold valid straight out of reset.
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNext();
        toNext();
        setIn(1, 1, 0, 1, 0, 1, 0, 2, 0);
        n_rsp1 = 0;
        for (int c = 0; c < 12; c++) begin
            atNegedge();
            check1("rr ready overlap", {31'b0, req0_ready & req1_ready}, 32'h0);
            check1("rr rsp overlap", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) begin
                rsp0_cycles.push_back(c);
                check1("rr rsp0_rdata", rsp0_rdata, 32'h1111_1111);
            end
            if (rsp1_valid) begin
                n_rsp1++;
                check1("rr rsp1_rdata", rsp1_rdata, 32'h2222_2222);
            end
            toNext();
        end
        check1("rr grant count", grants.size(), 4);
        for (int g = 0; g < grants.size() && g < 4; g++)
            check1($sformatf("rr grant %0d", g), grants[g], g % 2);
        check1("rr rsp0 count", rsp0_cycles.size(), 2);
        check1("rr rsp1 count", n_rsp1, 2);
        if (rsp0_cycles.size() == 2)
            check1("rr rsp0 spacing", rsp0_cycles[1] - rsp0_cycles[0], 6);

        // Reset during ISSUE of a port 1 write: write lands, no response.
        setIn(1, 0, 0, 0, 0, 1, 1, 7, 32'h55);
        atNegedge();
        check1("rstI accept", {31'b0, req1_ready}, 32'h1);
        toNext();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge();
        check1("rstI mem_wr", {31'b0, mem_wr}, 32'h1);
        toNext();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge();
        check1("rstI no rsp1", {31'b0, rsp1_valid}, 32'h0);
        check1("rstI no rsp0", {31'b0, rsp0_valid}, 32'h0);
        toNext();
        setIn(1, 1, 0, 7, 0, 1, 0, 2, 0);
        atNegedge();
        check1("rstI idle grant0", {req1_ready, req0_ready}, 32'h1);
        toNext();
        setIn(1, 0, 0, 0, 0, 1, 0, 2, 0);
        atNegedge();
        check1("rstI issue addr", {25'b0, mem_addr}, 32'd7);
        toNext();
        atNegedge();
        check1("rstI rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
        check1("rstI readback", rsp0_rdata, 32'h55);
        toNext();

        // Reset during RESP: pulse still visible, last_grant back to 1.
        setIn(1, 1, 0, 13, 0, 0, 0, 0, 0);
        atNegedge();
        check1("rstR accept", {31'b0, req0_ready}, 32'h1);
        toNext();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge(); toNext();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge();
        check1("rstR rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
        check1("rstR rsp0_rdata", rsp0_rdata, 32'h3);
        toNext();
        setIn(1, 1, 0, 1, 0, 1, 0, 2, 0);
        atNegedge();
        check1("rstR tie grant0", {req1_ready, req0_ready}, 32'h1);
        toNext();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        atNegedge(); toNext();
        atNegedge();
        check1("rstR rsp0 after", rsp0_rdata, 32'h1111_1111);
        toNext();

`ifdef DMEM_ARB_STATS_EN
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNext();
        atNegedge();
        check1("stats reset cnt0", {30'b0, stat_cnt0}, 32'h0);
        check1("stats reset cnt1", {30'b0, stat_cnt1}, 32'h0);
        toNext();
        for (int k = 0; k < 5; k++) doTxn(0, 0, 13, 0);
        for (int k = 0; k < 2; k++) doTxn(1, 1, 100, 32'h1234);
        atNegedge();
        check1("stats cnt0 saturated", {30'b0, stat_cnt0}, 32'h3);
        check1("stats cnt1", {30'b0, stat_cnt1}, 32'h2);
        toNext();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNext();
        atNegedge();
        check1("stats clear cnt0", {30'b0, stat_cnt0}, 32'h0);
        check1("stats clear cnt1", {30'b0, stat_cnt1}, 32'h0);
        toNext();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the 128x32 data memory, which has a registered read port and mem_wr/mem_rd strobes. Port 0 is the core load/store unit; port 1 is the loader/debug port. The block grants one requester round-robin and drives the memory command for one cycle. It returns a one-cycle response pulse carrying read data, or acknowledging a write.

Parameters:
ADDR_W, 7, memory word-address width
DATA_W, 32, data width
CNT_W, 16, width of the optional transaction counters

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 word address
req0_wdata  in  DATA_W  port 0 write data
rsp0_valid  out  1  port 0 response pulse
rsp0_rdata  out  DATA_W  port 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  as port 0, for port 1
mem_addr  out  ADDR_W  to memory addr
mem_wr  out  1  to memory mem_wr
mem_rd  out  1  to memory mem_rd
mem_wr_data  out  DATA_W  to memory wr_data
mem_read_data  in  DATA_W  from memory read_data

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Registers: state, owner (1 bit), is_write, last_grant (1 bit), mem_addr, mem_wr_data, mem_wr, mem_rd.
- Reset (rst_n low at posedge): state=IDLE, last_grant=1 so port 0 wins first, owner=0, is_write=0, mem_addr=0, mem_wr_data=0, mem_wr=0, mem_rd=0. Any in-flight transaction is dropped without a response.
- Grant logic is combinational and evaluated only in IDLE:
  - Single valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - reqN_ready = (state==IDLE) & grantN & reqN_valid. Ready is 0 in every other state.
- Accept (IDLE, some ready=1, at posedge):
  - Latch owner and last_grant = winner.
  - Latch mem_addr = addr and mem_wr_data = wdata.
  - Latch is_write = we; set mem_wr = we and mem_rd = ~we.
  - state -> ISSUE.
- ISSUE: exactly one of mem_wr/mem_rd is high for this single cycle; the memory acts at the closing edge. At that edge: mem_wr=0, mem_rd=0, state -> RESP.
- RESP: rsp<owner>_valid=1 for exactly this cycle.
  - Read: rsp<owner>_rdata = mem_read_data.
  - Write: rsp<owner>_rdata = 0.
  - Non-owner rsp_valid=0 and rsp_rdata=0.
  - state -> IDLE at the next edge.
- rspN_valid and rspN_rdata are decoded from registered state and owner; no combinational path from req* to rsp*.
- Latency: accept at edge closing cycle N; memory strobe in N+1; response in N+2; next accept possible in cycle N+3. Throughput is one transaction per 3 cycles.
- mem_addr and mem_wr_data hold their last latched value outside ISSUE. mem_wr and mem_rd are never both 1.
- Requesters hold valid, we, addr and wdata stable until ready. Withdrawing valid before ready is legal; no transaction occurs.
- Reset while in ISSUE: the memory operation still completes at that edge because the strobe was already registered high. state becomes IDLE with no rsp pulse, and last_grant returns to 1.
- Reset while in RESP: the response pulse in that cycle is still seen. Next state is IDLE.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds outputs stat_cnt0 and stat_cnt1 (CNT_W each).
  - Each increments by 1 at the edge where reqN_ready & reqN_valid (accept). Counts saturate at all-ones.
  - Both clear to 0 on reset.
- Undefined: no ports and no counter logic; behaviour is otherwise identical.

Test Plan:
- Memory word 13 preloaded with 3; port 0 reads addr 13 alone -> req0_ready=1 in cycle 0, mem_rd=1 with mem_addr=13 in cycle 1, rsp0_valid=1 with rsp0_rdata=3 in cycle 2, req0_ready=1 again in cycle 3.
- Port 1 writes addr 5 = 0xDEADBEEF, then port 0 reads addr 5 -> mem_wr=1 for one cycle; rsp1_valid pulse with rsp1_rdata=0; rsp0_rdata=0xDEADBEEF.
- Both ports hold valid from reset, port 0 reading addr 1 and port 1 reading addr 2 -> grant order 0,1,0,1; each port gets one rsp pulse every 6 cycles; rsp pulses never overlap.
- Port 1 writes addr 7 = 0x55, with rst_n low for the single ISSUE cycle -> no rsp1_valid; state IDLE afterwards; a later port 0 read of addr 7 returns 0x55; with both valid, port 0 is granted first.
- mem_wr and mem_rd checked every cycle: never both 1, and each high only for a single cycle per transaction.
- With DMEM_ARB_STATS_EN and CNT_W=2: port 0 makes 5 reads and port 1 makes 2 writes -> stat_cnt0=3 (saturated), stat_cnt1=2; reset clears both to 0.
